arb_resp_router: RTL



---
 rtl/arb_resp_router.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/arb_resp_router.sv
// arb_resp_router: request FIFO + outstanding-ID queue behind the RR arbiter.
// Routes in-order slave responses back to the requester that issued them.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   flush_i              synchronous clear of both queues and the count
//   arb_req_i/arb_gnt_o  arbitrated request valid / grant back to arbiter
//   arb_data_i/arb_idx_i arbitrated payload and winning requester index
//   mst_valid_o/ready_i  registered request port towards the slave
//   mst_data_o/mst_idx_o request payload and its requester tag
//   rsp_valid_i/ready_o  in-order response from the slave
//   rsp_data_i           response payload
//   rsp_valid_o/ready_i  per-requester response handshake
//   rsp_data_o           response payload, broadcast to all requesters
//   outstanding_o        accepted-but-unanswered request count
//   idle_o               both queues empty
module arb_resp_router #(
   parameter int unsigned NumIn          = 4,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned RespWidth      = 32,
   parameter int unsigned ReqDepth       = 2,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned IdxWidth       = (NumIn > 1) ? $clog2(NumIn) : 1,
   localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 arb_req_i,
   output logic                 arb_gnt_o,
   input  logic [DataWidth-1:0] arb_data_i,
   input  logic [IdxWidth-1:0]  arb_idx_i,
   output logic                 mst_valid_o,
   input  logic                 mst_ready_i,
   output logic [DataWidth-1:0] mst_data_o,
   output logic [IdxWidth-1:0]  mst_idx_o,
   input  logic                 rsp_valid_i,
   output logic                 rsp_ready_o,
   input  logic [RespWidth-1:0] rsp_data_i,
   output logic [NumIn-1:0]     rsp_valid_o,
   input  logic [NumIn-1:0]     rsp_ready_i,
   output logic [RespWidth-1:0] rsp_data_o,
   output logic [OutW-1:0]      outstanding_o,
   output logic                 idle_o
);

   localparam int unsigned RPtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
   localparam int unsigned RCntW = $clog2(ReqDepth + 1);
   localparam int unsigned IPtrW =
      (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   localparam logic [RCntW-1:0] RFull = RCntW'(ReqDepth);
   localparam logic [RPtrW-1:0] RLast = RPtrW'(ReqDepth - 1);
   localparam logic [OutW-1:0]  IFull = OutW'(MaxOutstanding);
   localparam logic [IPtrW-1:0] ILast = IPtrW'(MaxOutstanding - 1);

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [RPtrW-1:0] req_inc(input logic [RPtrW-1:0] p);
      return (p == RLast) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [IPtrW-1:0] idq_inc(input logic [IPtrW-1:0] p);
      return (p == ILast) ? '0 : p + 1'b1;
   endfunction

   // ------------------------------------------------------------------
   // Request FIFO state
   // ------------------------------------------------------------------
   logic [DataWidth-1:0] req_data_q [ReqDepth];
   logic [IdxWidth-1:0]  req_idx_q  [ReqDepth];
   logic [RPtrW-1:0]     req_wr_q;
   logic [RPtrW-1:0]     req_rd_q;
   logic [RCntW-1:0]     req_cnt_q;
   logic                 req_full;
   logic                 req_empty;

   // ------------------------------------------------------------------
   // Outstanding-ID queue state; its occupancy is the outstanding count
   // ------------------------------------------------------------------
   logic [IdxWidth-1:0]  idq_q [MaxOutstanding];
   logic [IPtrW-1:0]     idq_wr_q;
   logic [IPtrW-1:0]     idq_rd_q;
   logic [OutW-1:0]      idq_cnt_q;
   logic                 idq_empty;
   logic                 idq_full;

   logic                 accept;
   logic                 mst_pop;
   logic                 rsp_pop;
   logic                 rsp_ok;
   logic [IdxWidth-1:0]  push_idx;
   logic [IdxWidth-1:0]  head;
   logic [NumIn-1:0]     head_oh;

   assign req_full  = (req_cnt_q == RFull);
   assign req_empty = (req_cnt_q == '0);
   assign idq_full  = (idq_cnt_q == IFull);
   assign idq_empty = (idq_cnt_q == '0);

   // Grant is a function of registered state and flush only, never of
   // arb_req_i, so a vld/rdy-style arbiter cannot form a comb loop.
   // The count limit also blocks the grant while a pop is pending on a
   // full FIFO; the slot frees only on the next edge.
   assign arb_gnt_o = ~req_full & ~idq_full & ~flush_i;
   assign accept    = arb_req_i & arb_gnt_o;

   // With a single requester the index carries no information.
   assign push_idx = (NumIn > 1) ? arb_idx_i : '0;

   // ------------------------------------------------------------------
   // Request path
   // ------------------------------------------------------------------
   // Valid is withheld during flush so no handshake is silently lost.
   assign mst_valid_o = ~req_empty & ~flush_i;
   assign mst_pop     = mst_valid_o & mst_ready_i;
   assign mst_data_o  = req_data_q[req_rd_q];
   assign mst_idx_o   = req_idx_q[req_rd_q];

   always_ff @(posedge clk_i) begin
      if (accept) begin
         req_data_q[req_wr_q] <= arb_data_i;
         req_idx_q[req_wr_q]  <= push_idx;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_wr_q  <= '0;
         req_rd_q  <= '0;
         req_cnt_q <= '0;
      end else if (flush_i) begin
         req_wr_q  <= '0;
         req_rd_q  <= '0;
         req_cnt_q <= '0;
      end else begin
         if (accept)
            req_wr_q <= req_inc(req_wr_q);
         if (mst_pop)
            req_rd_q <= req_inc(req_rd_q);
         if (accept && !mst_pop)
            req_cnt_q <= req_cnt_q + 1'b1;
         else if (!accept && mst_pop)
            req_cnt_q <= req_cnt_q - 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Response routing (combinational, zero latency)
   // ------------------------------------------------------------------
   assign head   = idq_q[idq_rd_q];
   assign rsp_ok = ~idq_empty & ~flush_i;

   always_comb begin
      head_oh = '0;
      for (int i = 0; i < NumIn; i++)
         head_oh[i] = (head == IdxWidth'(i));
   end

   assign rsp_valid_o = (rsp_valid_i && rsp_ok) ? head_oh : '0;
   assign rsp_ready_o = (|(rsp_ready_i & head_oh)) & rsp_ok;
   assign rsp_pop     = rsp_valid_i & rsp_ready_o;
   assign rsp_data_o  = rsp_data_i;

   always_ff @(posedge clk_i) begin
      if (accept)
         idq_q[idq_wr_q] <= push_idx;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idq_wr_q  <= '0;
         idq_rd_q  <= '0;
         idq_cnt_q <= '0;
      end else if (flush_i) begin
         idq_wr_q  <= '0;
         idq_rd_q  <= '0;
         idq_cnt_q <= '0;
      end else begin
         if (accept)
            idq_wr_q <= idq_inc(idq_wr_q);
         if (rsp_pop)
            idq_rd_q <= idq_inc(idq_rd_q);
         if (accept && !rsp_pop)
            idq_cnt_q <= idq_cnt_q + 1'b1;
         else if (!accept && rsp_pop)
            idq_cnt_q <= idq_cnt_q - 1'b1;
      end
   end

   assign outstanding_o = idq_cnt_q;
   assign idle_o        = req_empty & idq_empty;

   // ------------------------------------------------------------------
   // Properties
   // ------------------------------------------------------------------
   a_rsp_onehot: assert property (
      @(posedge clk_i) disable iff (rst_i)
      $onehot0(rsp_valid_o));

   a_mst_stable: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (mst_valid_o && !mst_ready_i && !flush_i) |=>
         ((mst_valid_o || flush_i) &&
          $stable(mst_data_o) && $stable(mst_idx_o)));

   a_no_over: assert property (
      @(posedge clk_i) disable iff (rst_i)
      !(accept && idq_full));

   // A response with nothing outstanding is stalled, not dropped.
   a_stray_rsp: assert property (
      @(posedge clk_i) disable iff (rst_i)
      !(rsp_valid_i && idq_empty && !flush_i))
      else $warning("arb_resp_router: response with no outstanding id");

endmodule
